// File: rtl/sdp_rdma_atom_split_pkg.sv
// Shared SDP RDMA constants and mask helpers used by the unpack stage and the atom splitter.
package sdp_rdma_atom_split_pkg;

    localparam int SDP_ATOM_W = 256;
    localparam int SDP_ATOMS  = 4;
    localparam int SDP_CNT_W  = 32;

    // Only contiguous-from-lane-0 masks are produced by a well-behaved unpack stage.
    localparam logic [3:0] MASK_1 = 4'h1;
    localparam logic [3:0] MASK_2 = 4'h3;
    localparam logic [3:0] MASK_3 = 4'h7;
    localparam logic [3:0] MASK_4 = 4'hf;

    function automatic logic [2:0] mask_popcount(input logic [3:0] m);
        return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
    endfunction

    function automatic logic mask_legal(input logic [3:0] m);
        return (m == MASK_1) || (m == MASK_2) || (m == MASK_3) || (m == MASK_4);
    endfunction

endpackage

// File: rtl/sdp_rdma_atom_split_if.sv
// Packed-beat input channel and single-atom output channel of the atom splitter.
interface sdp_rdma_atom_split_if #(
    parameter int ATOM_W = sdp_rdma_atom_split_pkg::SDP_ATOM_W,
    parameter int ATOMS  = sdp_rdma_atom_split_pkg::SDP_ATOMS
);
    logic                        inp_pvld;
    logic                        inp_prdy;
    logic [ATOMS*ATOM_W+ATOMS-1:0] inp_data;
    logic                        out_pvld;
    logic                        out_prdy;
    logic [ATOM_W-1:0]           out_data;
    logic [1:0]                  out_idx;
    logic                        out_last;
    logic                        out_layer_end;

    // slave is the splitter's view; master is the surrounding datapath.
    modport slave (
        input  inp_pvld, inp_data, out_prdy,
        output inp_prdy, out_pvld, out_data, out_idx, out_last, out_layer_end
    );

    modport master (
        output inp_pvld, inp_data, out_prdy,
        input  inp_prdy, out_pvld, out_data, out_idx, out_last, out_layer_end
    );
endinterface

// File: rtl/sdp_rdma_atom_split.sv
// Re-serialises packed SDP RDMA beats into one atom per cycle, tagging lane index,
// beat-last and layer-end, and flagging malformed valid masks.
module sdp_rdma_atom_split
    import sdp_rdma_atom_split_pkg::*;
#(
    parameter int ATOM_W = SDP_ATOM_W,
    parameter int ATOMS  = SDP_ATOMS,
    parameter int CNT_W  = SDP_CNT_W
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rst,
    sdp_rdma_atom_split_if.slave  bus,
    input  logic [CNT_W-1:0]      cfg_atom_num,
    output logic                  op_done,
    output logic                  err_mask
);

    logic                          hold_vld_q, hold_vld_d;
    logic [1:0]                    seg_q, seg_d;
    logic [3:0]                    hold_mask_q, hold_mask_d;
    logic [ATOMS-1:0][ATOM_W-1:0]  hold_data_q, hold_data_d;
    logic [CNT_W-1:0]              atom_cnt_q, atom_cnt_d;
    logic                          op_done_q, op_done_d;
    logic                          err_q, err_d;

    logic [3:0] in_mask;
    logic       in_legal;
    logic       in_acc;
    logic       out_acc;
    logic [2:0] hold_n;
    logic       last;
    logic       layer_end;

    assign in_mask   = bus.inp_data[ATOMS*ATOM_W +: 4];
    assign in_legal  = mask_legal(in_mask);
    assign hold_n    = mask_popcount(hold_mask_q);
    assign last      = hold_vld_q && ({1'b0, seg_q} == hold_n - 3'd1);
    assign layer_end = hold_vld_q && (atom_cnt_q == cfg_atom_num);
    assign out_acc   = hold_vld_q && bus.out_prdy;

    // Accepting on the last-atom handshake is what removes the bubble between beats.
    assign bus.inp_prdy      = !hold_vld_q || (out_acc && last);
    assign in_acc            = bus.inp_pvld && bus.inp_prdy;

    assign bus.out_pvld      = hold_vld_q;
    assign bus.out_data      = hold_data_q[seg_q];
    assign bus.out_idx       = seg_q;
    assign bus.out_last      = last;
    assign bus.out_layer_end = layer_end;
    assign op_done           = op_done_q;
    assign err_mask          = err_q;

    always_comb begin
        hold_vld_d  = hold_vld_q;
        seg_d       = seg_q;
        hold_mask_d = hold_mask_q;
        hold_data_d = hold_data_q;
        atom_cnt_d  = atom_cnt_q;
        err_d       = err_q;
        op_done_d   = out_acc && layer_end;

        // A legal reload overrides the drain of the previous beat's last atom.
        if (in_acc && in_legal) begin
            hold_vld_d  = 1'b1;
            seg_d       = 2'd0;
            hold_mask_d = in_mask;
            hold_data_d = bus.inp_data[ATOMS*ATOM_W-1:0];
        end else if (out_acc) begin
            if (last) begin
                hold_vld_d = 1'b0;
                seg_d      = 2'd0;
            end else begin
                seg_d = seg_q + 2'd1;
            end
        end

        if (in_acc && !in_legal) begin
            err_d = 1'b1;
        end

        if (out_acc) begin
            atom_cnt_d = layer_end ? '0 : atom_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            hold_vld_q  <= 1'b0;
            seg_q       <= 2'd0;
            hold_mask_q <= 4'h0;
            atom_cnt_q  <= '0;
            op_done_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            hold_vld_q  <= hold_vld_d;
            seg_q       <= seg_d;
            hold_mask_q <= hold_mask_d;
            atom_cnt_q  <= atom_cnt_d;
            op_done_q   <= op_done_d;
            err_q       <= err_d;
        end
    end

    // Payload is qualified by hold_vld_q, so it carries no reset.
    always_ff @(posedge nvdla_core_clk) begin
        hold_data_q <= hold_data_d;
    end

endmodule

// File: tb/tb_sdp_rdma_atom_split.sv
// Directed and randomized checks of sdp_rdma_atom_split against an atom-stream model.
module tb_sdp_rdma_atom_split;

    localparam int AW = 256;
    localparam int NA = 4;
    localparam int CW = 32;

    typedef struct {
        logic [AW-1:0] data;
        logic [1:0]    idx;
        logic          last;
        logic          le;
    } atom_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] cfg;
    logic          op_done;
    logic          err_mask;

    always #5 clk = ~clk;

    sdp_rdma_atom_split_if #(.ATOM_W(AW), .ATOMS(NA)) bus ();

    sdp_rdma_atom_split #(.ATOM_W(AW), .ATOMS(NA), .CNT_W(CW)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .bus            (bus.slave),
        .cfg_atom_num   (cfg),
        .op_done        (op_done),
        .err_mask       (err_mask)
    );

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] atoms [4];
    logic [3:0]    cur_mask;
    atom_t         exp_q [$];
    longint        model_ord;

    logic          o_pvld, o_last, o_le, o_done, o_err, i_prdy;
    logic [1:0]    o_idx;
    logic [AW-1:0] o_data;
    bit            in_acc, out_acc;

    function automatic bit tb_legal(input logic [3:0] m);
        int v;
        v = int'(m);
        return (v != 0) && ((v & (v + 1)) == 0);
    endfunction

    function automatic int tb_count(input logic [3:0] m);
        int c = 0;
        for (int i = 0; i < 4; i++) if (m[i]) c++;
        return c;
    endfunction

    task automatic set_beat(input logic [3:0] m);
        for (int a = 0; a < 4; a++)
            for (int w = 0; w < 8; w++)
                atoms[a][w*32 +: 32] = $urandom();
        bus.inp_data = {m, atoms[3], atoms[2], atoms[1], atoms[0]};
        cur_mask = m;
    endtask

    // Samples outputs with current inputs settled, updates the model, then crosses one edge.
    task automatic step();
        atom_t a;
        int    n;
        #1;
        o_pvld = bus.out_pvld;  o_idx = bus.out_idx;  o_data = bus.out_data;
        o_last = bus.out_last;  o_le  = bus.out_layer_end;
        i_prdy = bus.inp_prdy;  o_done = op_done;     o_err = err_mask;
        in_acc  = bus.inp_pvld && i_prdy && !rst;
        out_acc = o_pvld && bus.out_prdy && !rst;
        if (rst) begin
            exp_q.delete();
            model_ord = 0;
        end else if (in_acc && tb_legal(cur_mask)) begin
            n = tb_count(cur_mask);
            for (int i = 0; i < n; i++) begin
                a.data = atoms[i];
                a.idx  = 2'(i);
                a.last = (i == n - 1);
                a.le   = ((model_ord % (longint'(cfg) + 1)) == longint'(cfg));
                exp_q.push_back(a);
                model_ord++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.inp_pvld = 1'b0; bus.out_prdy = 1'b1; cfg = '1;
        bus.inp_data = '0; cur_mask = 4'h0;
        @(posedge clk); #1;
        repeat (3) step();
        rst = 1'b0;
        step();
        total++; if (i_prdy !== 1'b1) begin bad++; $display("FAIL reset_prdy got=%b exp=1", i_prdy); end
        total++; if (o_pvld !== 1'b0) begin bad++; $display("FAIL reset_pvld got=%b exp=0", o_pvld); end
        total++; if (o_idx !== 2'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", o_idx); end
        total++; if ({o_last, o_le, o_done, o_err} !== 4'b0) begin
            bad++; $display("FAIL reset_flags got=%b exp=0000", {o_last, o_le, o_done, o_err});
        end
    endtask

    task automatic test_full_beat();
        set_beat(4'hf); bus.inp_pvld = 1'b1; bus.out_prdy = 1'b1;
        step();
        total++; if (!in_acc) begin bad++; $display("FAIL full_accept got=0 exp=1"); end
        bus.inp_pvld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            total++;
            if ({o_pvld, o_idx, o_last, o_data} !== {1'b1, 2'(k), (k == 3), atoms[k]}) begin
                bad++; $display("FAIL full_atom%0d got pvld=%b idx=%0d last=%b exp idx=%0d last=%b", k, o_pvld, o_idx, o_last, k, (k == 3));
            end
            total++; if (i_prdy !== (k == 3)) begin bad++; $display("FAIL full_prdy%0d got=%b exp=%b", k, i_prdy, (k == 3)); end
        end
        step();
        total++; if (o_pvld !== 1'b0) begin bad++; $display("FAIL full_idle got=%b exp=0", o_pvld); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] ed [6];
        logic [1:0]    ei [6];
        logic          el [6];
        set_beat(4'h3); bus.inp_pvld = 1'b1; bus.out_prdy = 1'b1;
        ed[0] = atoms[0]; ed[1] = atoms[1];
        step();
        set_beat(4'hf);
        for (int i = 0; i < 4; i++) ed[i+2] = atoms[i];
        ei = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3};
        el = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int c = 0; c < 6; c++) begin
            step();
            total++;
            if ({o_pvld, o_idx, o_last, o_data} !== {1'b1, ei[c], el[c], ed[c]}) begin
                bad++; $display("FAIL b2b_atom%0d got pvld=%b idx=%0d last=%b exp idx=%0d last=%b", c, o_pvld, o_idx, o_last, ei[c], el[c]);
            end
            total++; if (in_acc !== (c == 1)) begin bad++; $display("FAIL b2b_reload%0d got=%b exp=%b", c, in_acc, (c == 1)); end
            if (in_acc) bus.inp_pvld = 1'b0;
        end
        step();
        total++; if (o_pvld !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", o_pvld); end
    endtask

    task automatic test_stall();
        set_beat(4'hf); bus.inp_pvld = 1'b1; bus.out_prdy = 1'b1;
        step();
        bus.inp_pvld = 1'b0;
        step();
        bus.out_prdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if ({o_pvld, o_idx, o_data, i_prdy} !== {1'b1, 2'd1, atoms[1], 1'b0}) begin
                bad++; $display("FAIL stall_hold%0d got pvld=%b idx=%0d prdy=%b exp pvld=1 idx=1 prdy=0", c, o_pvld, o_idx, i_prdy);
            end
        end
        bus.out_prdy = 1'b1;
        for (int k = 1; k < 4; k++) begin
            step();
            total++;
            if ({o_pvld, o_idx, o_data} !== {1'b1, 2'(k), atoms[k]}) begin
                bad++; $display("FAIL stall_resume%0d got pvld=%b idx=%0d exp idx=%0d", k, o_pvld, o_idx, k);
            end
        end
        step();
        total++; if (o_pvld !== 1'b0) begin bad++; $display("FAIL stall_idle got=%b exp=0", o_pvld); end
    endtask

    task automatic test_layer_end();
        rst = 1'b1; cfg = 32'd5; bus.inp_pvld = 1'b0; bus.out_prdy = 1'b1;
        step();
        rst = 1'b0;
        set_beat(4'hf); bus.inp_pvld = 1'b1;
        step();
        set_beat(4'h3);
        for (int c = 0; c < 6; c++) begin
            step();
            total++; if (o_le !== (c == 5)) begin bad++; $display("FAIL layer_end%0d got=%b exp=%b", c, o_le, (c == 5)); end
            total++; if (o_done !== 1'b0) begin bad++; $display("FAIL layer_early_done%0d got=%b exp=0", c, o_done); end
            if (in_acc) bus.inp_pvld = 1'b0;
        end
        step();
        total++; if ({o_done, o_pvld} !== 2'b10) begin bad++; $display("FAIL layer_done got done=%b pvld=%b exp done=1 pvld=0", o_done, o_pvld); end
        step();
        total++; if (o_done !== 1'b0) begin bad++; $display("FAIL layer_done_pulse got=%b exp=0", o_done); end
        cfg = '0;
        set_beat(4'h1); bus.inp_pvld = 1'b1;
        step();
        bus.inp_pvld = 1'b0;
        step();
        total++; if ({o_pvld, o_le} !== 2'b11) begin bad++; $display("FAIL layer_cnt_clear got pvld=%b le=%b exp 11", o_pvld, o_le); end
        step();
        total++; if (o_done !== 1'b1) begin bad++; $display("FAIL layer_done2 got=%b exp=1", o_done); end
    endtask

    task automatic test_bad_mask();
        rst = 1'b1; cfg = '1; bus.inp_pvld = 1'b0; bus.out_prdy = 1'b1;
        step();
        rst = 1'b0;
        set_beat(4'h5); bus.inp_pvld = 1'b1;
        step();
        total++; if (!in_acc) begin bad++; $display("FAIL bad_accept got=0 exp=1"); end
        set_beat(4'h1);
        step();
        total++; if ({o_pvld, o_err} !== 2'b01) begin bad++; $display("FAIL bad_drop got pvld=%b err=%b exp pvld=0 err=1", o_pvld, o_err); end
        bus.inp_pvld = 1'b0;
        step();
        total++;
        if ({o_pvld, o_idx, o_last, o_data} !== {1'b1, 2'd0, 1'b1, atoms[0]}) begin
            bad++; $display("FAIL bad_next_single got pvld=%b idx=%0d last=%b exp pvld=1 idx=0 last=1", o_pvld, o_idx, o_last);
        end
        step();
        set_beat(4'h3); bus.inp_pvld = 1'b1;
        step();
        set_beat(4'h6);
        step();
        step();
        total++; if (!in_acc) begin bad++; $display("FAIL bad_drain_accept got=0 exp=1"); end
        bus.inp_pvld = 1'b0;
        step();
        total++; if ({o_pvld, o_err} !== 2'b01) begin bad++; $display("FAIL bad_drain_idle got pvld=%b err=%b exp 01", o_pvld, o_err); end
    endtask

    task automatic test_reset_mid_beat();
        cfg = '1;
        set_beat(4'hf); bus.inp_pvld = 1'b1; bus.out_prdy = 1'b1;
        step();
        bus.inp_pvld = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        total++;
        if ({o_pvld, i_prdy, o_err} !== 3'b010) begin
            bad++; $display("FAIL rstmid_state got pvld=%b prdy=%b err=%b exp 010", o_pvld, i_prdy, o_err);
        end
        cfg = '0;
        set_beat(4'h3); bus.inp_pvld = 1'b1;
        step();
        bus.inp_pvld = 1'b0;
        step();
        total++;
        if ({o_pvld, o_idx, o_le, o_data} !== {1'b1, 2'd0, 1'b1, atoms[0]}) begin
            bad++; $display("FAIL rstmid_restart got pvld=%b idx=%0d le=%b exp pvld=1 idx=0 le=1", o_pvld, o_idx, o_le);
        end
        step();
        step();
    endtask

    task automatic test_random();
        atom_t         e;
        bit            need_new, pend_done, exp_err, prev_stall;
        logic [1:0]    p_idx;
        logic          p_last, p_le;
        logic [AW-1:0] p_data;
        logic [3:0]    m;
        int            beats, cyc;
        rst = 1'b1; cfg = CW'($urandom_range(0, 6)); bus.inp_pvld = 1'b0; bus.out_prdy = 1'b1;
        step();
        rst = 1'b0;
        need_new = 1; pend_done = 0; exp_err = 0; prev_stall = 0; beats = 0; cyc = 0;
        p_idx = '0; p_last = 0; p_le = 0; p_data = '0;
        while (cyc < 4000 && (beats < 150 || bus.inp_pvld || exp_q.size() > 0)) begin
            if (need_new && beats < 150) begin
                if ($urandom_range(0, 3) != 0) begin
                    if ($urandom_range(0, 4) != 0) begin
                        case ($urandom_range(0, 3))
                            0: m = 4'h1;
                            1: m = 4'h3;
                            2: m = 4'h7;
                            default: m = 4'hf;
                        endcase
                    end else begin
                        m = 4'(($urandom_range(0, 10) * 3 + 2) % 16);
                        if (tb_legal(m)) m = 4'h0;
                    end
                    set_beat(m);
                    bus.inp_pvld = 1'b1;
                    need_new = 0;
                    beats++;
                end
            end
            bus.out_prdy = ($urandom_range(0, 3) != 0);
            step();
            cyc++;
            total++; if (o_done !== pend_done) begin bad++; $display("FAIL rand_done cyc=%0d got=%b exp=%b", cyc, o_done, pend_done); end
            total++; if (o_err !== exp_err) begin bad++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", cyc, o_err, exp_err); end
            if (prev_stall) begin
                total++;
                if ({o_pvld, o_idx, o_last, o_le, o_data} !== {1'b1, p_idx, p_last, p_le, p_data}) begin
                    bad++; $display("FAIL rand_stable cyc=%0d got pvld=%b idx=%0d exp idx=%0d", cyc, o_pvld, o_idx, p_idx);
                end
            end
            pend_done = 0;
            if (out_acc) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rand_extra cyc=%0d got idx=%0d exp none", cyc, o_idx);
                end else begin
                    e = exp_q.pop_front();
                    pend_done = e.le;
                    if ({o_data, o_idx, o_last, o_le} !== {e.data, e.idx, e.last, e.le}) begin
                        bad++; $display("FAIL rand_atom cyc=%0d got idx=%0d last=%b le=%b exp idx=%0d last=%b le=%b", cyc, o_idx, o_last, o_le, e.idx, e.last, e.le);
                    end
                end
            end
            prev_stall = o_pvld && !out_acc;
            p_idx = o_idx; p_last = o_last; p_le = o_le; p_data = o_data;
            if (in_acc) begin
                if (!tb_legal(cur_mask)) exp_err = 1;
                need_new = 1;
                bus.inp_pvld = 1'b0;
            end
        end
        total++; if (cyc >= 4000) begin bad++; $display("FAIL rand_timeout got cycles=%0d exp <4000", cyc); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_missing got left=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_ord = 0;
        test_reset();
        test_full_beat();
        test_back_to_back();
        test_stall();
        test_layer_end();
        test_bad_mask();
        test_reset_mid_beat();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
